// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder between NREQ requesters.
// Ports: req_* parallel requests in, add_* serial adder link, rsp_* tagged result out, err sticky.
module serial_add_sched #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      add_st,
    output logic                      add_a,
    output logic                      add_b,
    input  logic                      add_sum,
    input  logic                      add_done,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH:0]            rsp_sum,
    output logic                      err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_rr;
    logic [IW-1:0]    r_gid;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_rsp_valid;
    logic [IW-1:0]    r_rsp_id;
    logic [WIDTH:0]   r_rsp_sum;
    logic             r_err;

    logic [NREQ-1:0]  w_rot;
    logic [IW:0]      w_rsh;
    logic             w_found;
    logic [IW-1:0]    w_off;
    logic [IW:0]      w_sum;
    logic [IW-1:0]    w_gidx;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_last;
    logic             w_run;

    // Rotate valids so bit 0 is the rr pointer, then pick the lowest set bit.
    always_comb begin
        w_rsh   = (IW+1)'(NREQ) - {1'b0, r_rr};
        w_rot   = (req_valid >> r_rr) | (req_valid << w_rsh);
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IW'(i);
            end
        end
        w_sum = {1'b0, r_rr} + {1'b0, w_off};
        if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
        end
        w_gidx = w_sum[IW-1:0];
        w_a    = '0;
        w_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IW'(i)) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_cnt == CW'(WIDTH));

    assign req_ready = (r_state == S_IDLE && w_found)
                     ? (NREQ'(1) << w_gidx) : '0;

    // Operands are shifted right each bit cycle, so bit 0 is always current.
    assign add_st = w_run && (r_cnt == '0);
    assign add_a  = w_run && !w_last && r_opa[0];
    assign add_b  = w_run && !w_last && r_opb[0];

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rr        <= '0;
            r_gid       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_res       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_opa   <= w_a;
                        r_opb   <= w_b;
                        r_gid   <= w_gidx;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        // Carry-out cycle: add_sum carries the top result bit.
                        r_rsp_sum   <= {add_sum, r_res};
                        r_rsp_id    <= r_gid;
                        r_rsp_valid <= 1'b1;
                        if (!add_done) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_res <= WIDTH'({add_sum, r_res} >> 1);
                        r_opa <= r_opa >> 1;
                        r_opb <= r_opb >> 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // No accept here: the adder needs its return-to-idle cycle.
                    r_rr    <= (r_gid == IW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched with a behavioural bit-serial adder model.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_serial_add_sched;

    localparam int NREQ = 2;
    localparam int W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              add_st;
    logic              add_a;
    logic              add_b;
    logic              add_sum;
    logic              add_done;
    logic              rsp_valid;
    logic [0:0]        rsp_id;
    logic [W:0]        rsp_sum;
    logic              err;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;
    logic withhold = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_st    (add_st),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_done  (add_done),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .err       (err)
    );

    // Serial adder model: start cycle is bit 0, W bits, then a carry/done cycle.
    int   m_k;
    logic m_c;
    logic m_cin;

    always_comb begin
        m_cin    = add_st ? 1'b0 : m_c;
        add_sum  = (m_k == W) ? m_c : (add_a ^ add_b ^ m_cin);
        add_done = (m_k == W) && !withhold;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0;
            m_c <= 1'b0;
        end else if (add_st) begin
            m_k <= 1;
            m_c <= add_a & add_b;
        end else if (m_k != 0 && m_k < W) begin
            m_k <= m_k + 1;
            m_c <= (add_a & add_b) | (add_a & m_c) | (add_b & m_c);
        end else if (m_k == W) begin
            m_k <= 0;
        end
    end

    typedef struct {
        int id;
        int a;
        int b;
        int sum;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive(input int id, input int a, input int b);
        req_valid[id]      = 1'b1;
        req_a[id*W +: W]   = a[W-1:0];
        req_b[id*W +: W]   = b[W-1:0];
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " req_ready"}, req_ready, 0);
        chk({tag, " add_st"}, add_st, 0);
        chk({tag, " add_a/b"}, {add_a, add_b}, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_id"}, rsp_id, 0);
        chk({tag, " rsp_sum"}, rsp_sum, 0);
        chk({tag, " err"}, err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full operation from IDLE; returns at the DONE cycle (+1).
    task automatic run_op(input int id, input int a, input int b,
                          input int exp, input int exp_err);
        bit ok;
        int st_bad;
        int rv_early;
        @(negedge clk);
        drive(id, a, b);
        wait_ready(ok);
        if (!ok) begin
            chk("accept timeout", 0, 1);
            req_valid = '0;
            return;
        end
        chk("req_ready onehot", req_ready, 1 << id);
        st_bad   = 0;
        rv_early = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[id] = 1'b0;
            #1;
            if (c == 1) chk("add_st at T+1", add_st, 1);
            else if (add_st) st_bad++;
            if (c < 6 && rsp_valid) rv_early++;
        end
        chk("add_st extra", st_bad, 0);
        chk("rsp_valid early", rv_early, 0);
        chk("rsp_valid T+6", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_sum", rsp_sum, exp);
        chk("err", err, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   opa[8];
        int   opb[8];
        int   g;
        int   tprev;
        int   rv;
        int   rdy_bad;
        bit   ok;

        tbl[0] = '{0, 5'h5, 5'h3, 5'h08};
        tbl[1] = '{1, 5'hF, 5'hF, 5'h1E};
        tbl[2] = '{1, 5'h0, 5'h0, 5'h00};
        tbl[3] = '{0, 5'hF, 5'h1, 5'h10};
        tbl[4] = '{1, 5'h7, 5'h8, 5'h0F};
        tbl[5] = '{0, 5'hA, 5'h5, 5'h0F};
        tbl[6] = '{0, 5'hC, 5'h6, 5'h12};

        opa = '{1, 3, 15, 8, 5, 14, 0, 12};
        opb = '{2, 4, 1, 8, 10, 3, 15, 12};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed single-requester vectors
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, 0);
        end

        // Both requesters continuously valid: alternate grants, 7-cycle spacing
        do_reset();
        @(negedge clk);
        drive(0, opa[0], opb[0]);
        drive(1, opa[1], opb[1]);
        tprev = 0;
        for (int i = 0; i < 8; i++) begin
            wait_ready(ok);
            if (!ok) begin
                chk("rr accept timeout", 0, 1);
                break;
            end
            g = req_ready[1] ? 1 : 0;
            chk("rr grant", g, i % 2);
            chk("rr onehot", req_ready, 1 << g);
            if (i > 0) chk("rr spacing", cyc - tprev, 7);
            tprev = cyc;
            @(negedge clk);
            if (i + 2 < 8) drive(g, opa[i+2], opb[i+2]);
            else req_valid[g] = 1'b0;
            repeat (5) @(negedge clk);
            #1;
            chk("rr rsp_valid", rsp_valid, 1);
            chk("rr rsp_id", rsp_id, i % 2);
            chk("rr rsp_sum", rsp_sum, opa[i] + opb[i]);
            @(negedge clk);
        end
        req_valid = '0;

        // Reset in the middle of an operation
        @(negedge clk);
        drive(0, 3, 6);
        wait_ready(ok);
        chk("mid-reset accept", ok, 1);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid-reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (rsp_valid) rv++;
        end
        chk("no rsp after reset", rv, 0);
        run_op(0, 9, 7, 5'h10, 0);

        // Adder withholds add_done: sticky err, result still delivered
        withhold = 1'b1;
        run_op(0, 1, 2, 3, 1);
        withhold = 1'b0;
        run_op(1, 4, 4, 8, 1);
        do_reset();
        #1;
        chk("err cleared by reset", err, 0);

        // req0 drops valid in DONE while req1 waits: no accept in DONE
        @(negedge clk);
        drive(0, 2, 2);
        wait_ready(ok);
        chk("drop accept0", req_ready, 1);
        rdy_bad = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) drive(1, 6, 5);
            #1;
            if (req_ready != '0) rdy_bad++;
        end
        chk("ready during run", rdy_bad, 0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        chk("drop rsp_valid", rsp_valid, 1);
        chk("drop rsp_sum", rsp_sum, 4);
        chk("no accept in DONE", req_ready, 0);
        @(negedge clk);
        #1;
        chk("req1 granted", req_ready, 2);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
        end
        #1;
        chk("req1 rsp_valid", rsp_valid, 1);
        chk("req1 rsp_id", rsp_id, 1);
        chk("req1 rsp_sum", rsp_sum, 5'h0B);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
